// File: rtl/reg_dump_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_pkg
//   Shared definitions for the register-file dump reader:
//   - default widths (XLEN, IDX_W, NUM_REGS)
//   - the dump FSM state encoding
//   - range_ok(): legality test applied to a start request
//   Optional build macro used by the files that import this package:
//   REG_DUMP_CHECKSUM_EN (appends an XOR checksum word to every dump).
// -----------------------------------------------------------------------------
package reg_dump_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int IDX_W_DEF    = 5;
  localparam int NUM_REGS_DEF = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
    CKSUM = 3'd3,
    DONE  = 3'd4
  } state_t;

  // A dump range is legal when it is non-empty in ascending order and the
  // last index names an existing register, so the index counter can never
  // wrap while it walks the range.
  function automatic logic range_ok(input int unsigned first,
                                    input int unsigned last,
                                    input int unsigned num_regs);
    return (first <= last) && (last < num_regs);
  endfunction

endpackage

// File: rtl/reg_dump_reader_if.sv
// -----------------------------------------------------------------------------
// reg_dump_reader_if
//   Valid/ready stream carrying dumped register words.
//   Signals:
//     dump_valid  producer -> consumer  word valid
//     dump_ready  consumer -> producer  word accepted
//     dump_data   producer -> consumer  captured register value (or checksum)
//     dump_idx    producer -> consumer  register index of dump_data
//     dump_last   producer -> consumer  final word of the dump
//     dump_cksum  producer -> consumer  word is the checksum
//   Modports: master (the dump reader), slave (the consumer).
// -----------------------------------------------------------------------------
interface reg_dump_reader_if
  import reg_dump_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int IDX_W = IDX_W_DEF
);

  logic             dump_valid;
  logic             dump_ready;
  logic [XLEN-1:0]  dump_data;
  logic [IDX_W-1:0] dump_idx;
  logic             dump_last;
  logic             dump_cksum;

  modport master (
    output dump_valid,
    input  dump_ready,
    output dump_data,
    output dump_idx,
    output dump_last,
    output dump_cksum
  );

  modport slave (
    input  dump_valid,
    output dump_ready,
    input  dump_data,
    input  dump_idx,
    input  dump_last,
    input  dump_cksum
  );

endinterface

// File: rtl/reg_dump_cksum.sv
// -----------------------------------------------------------------------------
// reg_dump_cksum
//   XOR accumulator for the dump checksum. Only instantiated when the reader
//   is built with REG_DUMP_CHECKSUM_EN.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous active-high reset (accumulator -> 0)
//     clear  synchronous clear (new dump accepted); wins over en
//     en     fold din into the accumulator this cycle
//     din    word to accumulate
//     acc    running XOR of all words folded in since the last clear
// -----------------------------------------------------------------------------
module reg_dump_cksum
  import reg_dump_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            en,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc ^ din;
    end
  end

endmodule

// File: rtl/reg_dump.sv
// -----------------------------------------------------------------------------
// reg_dump_reader
//   Sweeps registers first_sel..last_sel of the register file through one
//   spare read port and streams each captured value out on a valid/ready
//   interface, tagged with its index.
//
//   Build option: REG_DUMP_CHECKSUM_EN
//     defined   : after the last register word, one extra word carries the
//                 XOR of every accepted data word (dump_cksum = 1,
//                 dump_last = 1, dump_idx = last_sel); the final register
//                 word then has dump_last = 0.
//     undefined : no checksum word, dump_cksum tied to 0.
//
//   Ports:
//     clk         rising-edge clock
//     reset       asynchronous active-high reset
//     start       one-cycle dump request, sampled only while idle
//     abort       synchronous cancel of the dump in progress (no done pulse)
//     first_sel   first register index, latched on an accepted start
//     last_sel    last register index (inclusive), latched on start
//     rd_sel      register-file read select
//     rd_data     combinational register-file read data for rd_sel
//     dump        reg_dump_reader_if.master output stream
//     busy        high from the cycle after start through the done cycle
//     done        one-cycle pulse after the final handshake
//     err         one-cycle pulse after a start with an illegal range
//
//   Timing: start at cycle 0, FETCH at cycle 1, first dump_valid at cycle 2;
//   best-case throughput is one word every two cycles.
// -----------------------------------------------------------------------------
module reg_dump_reader
  import reg_dump_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int IDX_W    = IDX_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] first_sel,
  input  logic [IDX_W-1:0] last_sel,
  output logic [IDX_W-1:0] rd_sel,
  input  logic [XLEN-1:0]  rd_data,
  reg_dump_reader_if.master dump,
  output logic             busy,
  output logic             done,
  output logic             err
);

`ifdef REG_DUMP_CHECKSUM_EN
  localparam state_t AFTER_LAST = CKSUM;
`else
  localparam state_t AFTER_LAST = DONE;
`endif

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;       // register being fetched / sent
  logic [IDX_W-1:0] last_q;      // inclusive end of the latched range
  logic [XLEN-1:0]  data_q;      // snapshot taken in FETCH
  logic [IDX_W-1:0] didx_q;      // index of data_q
  logic             err_q;

  // FSM decode strobes
  logic start_ok;
  logic load_range;  // accepted start: latch range, set idx
  logic capture;     // FETCH: snapshot rd_data
  logic advance;     // handshake on a non-final word: idx += 1
  logic data_hs;     // a register word was accepted by the consumer
  logic at_last;

  assign start_ok = range_ok(32'(first_sel), 32'(last_sel), NUM_REGS);
  assign at_last  = (idx_q == last_q);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked process uses non-blocking assignments so that all
  // registers update from the values they held before the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and control strobes
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_d    = state_q;
    load_range = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    data_hs    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && start_ok) begin
          load_range = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        capture = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        if (dump.dump_ready) begin
          data_hs = 1'b1;
          if (at_last) begin
            state_d = AFTER_LAST;
          end else begin
            advance = 1'b1;
            state_d = FETCH;
          end
        end
      end
      CKSUM: begin
        if (dump.dump_ready) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // abort beats everything, including a handshake in the same cycle: the
    // pending word is dropped and not counted into the checksum.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      capture = 1'b0;
      advance = 1'b0;
      data_hs = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      last_q <= '0;
      data_q <= '0;
      didx_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // start is only looked at while idle; a request during a dump is
      // silently ignored rather than flagged.
      err_q <= start && (state_q == IDLE) && !start_ok;

      if (load_range) begin
        idx_q  <= first_sel;
        last_q <= last_sel;
      end else if (advance) begin
        idx_q <= idx_q + IDX_W'(1);
      end

      if (capture) begin
        data_q <= rd_data;
        didx_q <= idx_q;
      end
    end
  end

  // idx only changes on the edge into FETCH, so driving the read select
  // straight from it presents idx during FETCH and holds the last fetched
  // index everywhere else.
  assign rd_sel = idx_q;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign err  = err_q;

  assign dump.dump_valid = (state_q == SEND) || (state_q == CKSUM);
  assign dump.dump_idx   = didx_q;

`ifdef REG_DUMP_CHECKSUM_EN
  logic [XLEN-1:0] cksum;

  reg_dump_cksum #(
    .XLEN (XLEN)
  ) u_cksum (
    .clk   (clk),
    .reset (reset),
    .clear (load_range),
    .en    (data_hs),
    .din   (data_q),
    .acc   (cksum)
  );

  // The checksum word is the only one flagged last; didx_q still holds
  // last_sel from the final register fetch.
  assign dump.dump_data  = (state_q == CKSUM) ? cksum : data_q;
  assign dump.dump_last  = (state_q == CKSUM);
  assign dump.dump_cksum = (state_q == CKSUM);
`else
  assign dump.dump_data  = data_q;
  assign dump.dump_last  = (state_q == SEND) && at_last;
  assign dump.dump_cksum = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_reader.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_reader
//   Self-checking bench for reg_dump_reader. A behavioural register file
//   feeds rd_data; the expected word stream of each dump is derived from the
//   register contents and the requested range and queued, and a monitor
//   compares every accepted word against the queue head.
//   Honours REG_DUMP_CHECKSUM_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_reg_dump_reader;

`ifdef REG_DUMP_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [4:0]  idx;
    logic        last;
    logic        cksum;
  } word_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [4:0]  first_sel;
  logic [4:0]  last_sel;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic        err;

  reg_dump_reader_if dump_if ();

  reg_dump_reader dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .first_sel (first_sel),
    .last_sel  (last_sel),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .dump      (dump_if),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural register file: x0 is hardwired to zero.
  logic [31:0] regs [32];
  assign rd_data = (rd_sel == 5'd0) ? 32'd0 : regs[rd_sel];

  function automatic logic [31:0] model_read(input int i);
    return (i == 0) ? 32'd0 : regs[i];
  endfunction

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    last_hs_cyc = -100;
  int    done_cnt = 0;
  int    err_cnt  = 0;
  word_t exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!reset && done) done_cnt++;
    if (!reset && err)  err_cnt++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({dump_if.dump_valid, dump_if.dump_data, dump_if.dump_idx,
                dump_if.dump_last, dump_if.dump_cksum, busy, done, err, rd_sel});
  endfunction

  // Expected stream for a dump of first..last. stop_at >= 0 means the dump
  // is cut off before word stop_at is accepted (abort/reset): only the words
  // before it are expected and no checksum word follows.
  function automatic void build_expected(input int first, input int last, input int stop_at);
    logic [31:0] x = 32'd0;
    word_t w;
    for (int i = first; i <= last; i++) begin
      if (stop_at >= 0 && i >= stop_at) return;
      w.data  = model_read(i);
      w.idx   = 5'(i);
      w.last  = !CK && (i == last);
      w.cksum = 1'b0;
      x ^= w.data;
      exp_q.push_back(w);
    end
    if (CK) begin
      w.data  = x;
      w.idx   = 5'(last);
      w.last  = 1'b1;
      w.cksum = 1'b1;
      exp_q.push_back(w);
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Consumer: ready pattern
  //   0: always ready   1: random   2: stall 3 cycles on stall_idx
  //   3: never ready on stall_idx
  // ---------------------------------------------------------------------------
  int ready_mode = 0;
  int stall_idx  = 0;
  int stall_cnt  = 0;

  initial begin
    dump_if.dump_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: dump_if.dump_ready = 1'b1;
        1: dump_if.dump_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (dump_if.dump_valid && dump_if.dump_idx == 5'(stall_idx) && stall_cnt < 3) begin
            dump_if.dump_ready = 1'b0;
            stall_cnt++;
          end else begin
            dump_if.dump_ready = 1'b1;
          end
        end
        default: dump_if.dump_ready = !(dump_if.dump_valid && dump_if.dump_idx == 5'(stall_idx));
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: compare accepted words, check stability while stalled
  // ---------------------------------------------------------------------------
  bit    held = 1'b0;
  word_t hw;

  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held) begin
        check("hold_valid", 64'(dump_if.dump_valid), 64'(1));
        check("hold_data",  64'(dump_if.dump_data),  64'(hw.data));
        check("hold_idx",   64'(dump_if.dump_idx),   64'(hw.idx));
        check("hold_last",  64'(dump_if.dump_last),  64'(hw.last));
      end
      held = 1'b0;
      if (dump_if.dump_valid && !abort) begin
        if (dump_if.dump_ready) begin
          check("word_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            word_t w;
            w = exp_q.pop_front();
            check("word_data",  64'(dump_if.dump_data),  64'(w.data));
            check("word_idx",   64'(dump_if.dump_idx),   64'(w.idx));
            check("word_last",  64'(dump_if.dump_last),  64'(w.last));
            check("word_cksum", 64'(dump_if.dump_cksum), 64'(w.cksum));
            if (w.last) last_hs_cyc = cyc;
          end
        end else begin
          held     = 1'b1;
          hw.data  = dump_if.dump_data;
          hw.idx   = dump_if.dump_idx;
          hw.last  = dump_if.dump_last;
          hw.cksum = dump_if.dump_cksum;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic pulse_start(input int first, input int last);
    @(posedge clk);
    #1;
    first_sel = 5'(first);
    last_sel  = 5'(last);
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Run one legal dump. abort_at >= 0 aborts while that index is presented;
  // poke issues a second start while the dump is running.
  task automatic run_dump(input int first, input int last, input int abort_at, input bit poke);
    bit got_done = 1'b0;
    bit aborted  = 1'b0;
    int done_before = done_cnt;
    int err_before  = err_cnt;

    build_expected(first, last, abort_at);
    pulse_start(first, last);

    // cycle 1: FETCH
    @(negedge clk);
    check("lat_busy",   64'(busy), 64'(1));
    check("lat_fetch",  64'(dump_if.dump_valid), 64'(0));
    check("lat_rd_sel", 64'(rd_sel), 64'(first));
    // cycle 2: first word presented
    @(negedge clk);
    check("lat_valid",      64'(dump_if.dump_valid), 64'(1));
    check("lat_first_idx",  64'(dump_if.dump_idx),   64'(first));
    check("lat_first_data", 64'(dump_if.dump_data),  64'(model_read(first)));

    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      #1;
      start = poke && (k == 4);
      if (poke && k == 4) begin
        first_sel = 5'd9;
        last_sel  = 5'd9;
      end
      if (aborted) begin
        abort = 1'b0;
        break;
      end
      if (abort_at >= 0 && dump_if.dump_valid && dump_if.dump_idx == 5'(abort_at)) begin
        abort   = 1'b1;
        aborted = 1'b1;
      end
      @(negedge clk);
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    start = 1'b0;

    if (abort_at >= 0) begin
      check("abort_seen",       64'(aborted), 64'(1));
      check("abort_valid_drop", 64'(dump_if.dump_valid), 64'(0));
      check("abort_busy",       64'(busy), 64'(0));
      repeat (3) @(negedge clk);
      check("abort_no_done", 64'(done_cnt), 64'(done_before));
      check("abort_idle",    64'(busy), 64'(0));
    end else begin
      check("done_seen",   64'(got_done), 64'(1));
      check("done_timing", 64'(cyc), 64'(last_hs_cyc + 1));
      @(negedge clk);
      check("done_pulse_len", 64'(done), 64'(0));
      check("busy_after",     64'(busy), 64'(0));
    end
    check("words_left", 64'(exp_q.size()), 64'(0));
    check("err_quiet",  64'(err_cnt), 64'(err_before));
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    bit found;
    int err_before;
    int f;
    int l;

    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    first_sel = 5'd0;
    last_sel  = 5'd0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);

    #3;
    check("reset_outs", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_outs", all_outs(), 64'd0);

    // Basic dump 1..4, consumer always ready.
    ready_mode = 0;
    run_dump(1, 4, -1, 1'b0);

    // Same dump, consumer stalls 3 cycles on idx 2.
    ready_mode = 2;
    stall_idx  = 2;
    stall_cnt  = 0;
    run_dump(1, 4, -1, 1'b0);
    check("stall_cycles", 64'(stall_cnt), 64'(3));

    // Single-register dumps after a write; x0 reads zero.
    ready_mode = 0;
    regs[7] = 32'h1234_5678;
    run_dump(7, 7, -1, 1'b0);
    run_dump(0, 0, -1, 1'b0);

    // Illegal range: err pulse only.
    err_before = err_cnt;
    pulse_start(5, 2);
    @(negedge clk);
    check("err_pulse",     64'(err), 64'(1));
    check("err_busy",      64'(busy), 64'(0));
    check("err_valid",     64'(dump_if.dump_valid), 64'(0));
    @(negedge clk);
    check("err_pulse_len", 64'(err), 64'(0));
    check("err_count",     64'(err_cnt), 64'(err_before + 1));
    check("err_still_idle", 64'(busy), 64'(0));

    // start while busy is ignored.
    ready_mode = 1;
    run_dump(0, 5, -1, 1'b1);

    // Random contents, random ranges, random backpressure.
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    for (int t = 0; t < 6; t++) begin
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      run_dump(f, l, -1, 1'b0);
    end
    run_dump(0, 31, -1, 1'b0);

    // Abort while idx 10 is presented, simultaneous with ready.
    ready_mode = 0;
    run_dump(0, 31, 10, 1'b0);

    // Asynchronous reset while idx 3 is waiting in SEND.
    ready_mode = 3;
    stall_idx  = 3;
    build_expected(0, 31, 3);
    pulse_start(0, 31);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (dump_if.dump_valid && dump_if.dump_idx == 5'd3) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reached_send", 64'(found), 64'(1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_outs", all_outs(), 64'd0);
    check("rst_words_left",   64'(exp_q.size()), 64'(0));
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("rst_release_outs", all_outs(), 64'd0);

    // Recovery after reset.
    run_dump(2, 3, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
